branch_ctrl_unit: RTL

//  Parametrised jump/branch control unit for the fetch path. It replaces hard-coded

---
 rtl/branch_ctrl_unit.sv | 130 +++++++++++++
 1 files changed

// File: rtl/branch_ctrl_unit.sv
// Jump/branch control for the fetch path: loadable target table, registered ALU flags
// and a saturating return-address stack for CALL/RET.
module branch_ctrl_unit #(
   parameter int unsigned IW        = 9,
   parameter int unsigned OPW       = 4,
   parameter int unsigned IDXW      = 5,
   parameter int unsigned PCW       = 16,
   parameter int unsigned RAS_DEPTH = 4
) (
   input  logic            Clk,
   input  logic            Reset,
   input  logic [IW-1:0]   Instruction,
   input  logic            ZERO,
   input  logic            GREATER,
   input  logic            flag_we,
   input  logic            advance,
   input  logic [PCW-1:0]  pc_next,
   input  logic            lut_we,
   input  logic [IDXW-1:0] lut_waddr,
   input  logic [PCW-1:0]  lut_wdata,
   output logic            jump_en,
   output logic [PCW-1:0]  Target,
   output logic            ras_overflow,
   output logic            ras_underflow
);

   localparam int unsigned CW      = $clog2(RAS_DEPTH + 1);
   localparam int unsigned Entries = 2 ** IDXW;

   localparam logic [OPW-1:0] kJ    = OPW'(1);
   localparam logic [OPW-1:0] kBRE  = OPW'(2);
   localparam logic [OPW-1:0] kBRGT = OPW'(3);
   localparam logic [OPW-1:0] kCALL = OPW'(4);
   localparam logic [OPW-1:0] kRET  = OPW'(5);

   logic [PCW-1:0]  r_lut [Entries];
   logic [PCW-1:0]  r_ras [RAS_DEPTH];
   logic [CW-1:0]   r_cnt;
   logic            r_zf;
   logic            r_gf;
   logic            r_ovf;
   logic            r_udf;

   logic [OPW-1:0]  w_op;
   logic [IDXW-1:0] w_idx;
   logic [PCW-1:0]  w_lut_rd;
   logic [PCW-1:0]  w_top;
   logic            w_ras_empty;
   logic            w_ras_full;

   assign w_op        = Instruction[IW-1 -: OPW];
   assign w_idx       = Instruction[IDXW-1:0];
   assign w_lut_rd    = r_lut[w_idx];
   assign w_ras_empty = (r_cnt == '0);
   assign w_ras_full  = (r_cnt == CW'(RAS_DEPTH));

   // Top-of-stack mux written as a loop so an empty stack never forms an out-of-range index.
   always_comb begin
      w_top = '0;
      for (int i = 0; i < int'(RAS_DEPTH); i++) begin
         if (CW'(i + 1) == r_cnt) w_top = r_ras[i];
      end
   end

   always_comb begin
      jump_en = 1'b0;
      Target  = '0;
      if (!Reset) begin
         case (w_op)
            kJ, kCALL: begin
               jump_en = 1'b1;
               Target  = w_lut_rd;
            end
            kBRE: begin
               jump_en = r_zf;
               Target  = r_zf ? w_lut_rd : '0;
            end
            kBRGT: begin
               jump_en = r_gf;
               Target  = r_gf ? w_lut_rd : '0;
            end
            kRET: begin
               jump_en = !w_ras_empty;
               Target  = w_ras_empty ? '0 : w_top;
            end
            default: begin
               jump_en = 1'b0;
               Target  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_zf  <= 1'b0;
         r_gf  <= 1'b0;
         r_cnt <= '0;
         r_ovf <= 1'b0;
         r_udf <= 1'b0;
         for (int i = 0; i < int'(Entries); i++) r_lut[i] <= '0;
         for (int i = 0; i < int'(RAS_DEPTH); i++) r_ras[i] <= '0;
      end else begin
         if (flag_we) begin
            r_zf <= ZERO;
            r_gf <= GREATER;
         end
         if (lut_we) r_lut[lut_waddr] <= lut_wdata;
         if (advance) begin
            if (w_op == kCALL) begin
               if (w_ras_full) begin
                  r_ovf <= 1'b1;
               end else begin
                  for (int i = 0; i < int'(RAS_DEPTH); i++) begin
                     if (CW'(i) == r_cnt) r_ras[i] <= pc_next;
                  end
                  r_cnt <= r_cnt + CW'(1);
               end
            end else if (w_op == kRET) begin
               if (w_ras_empty) r_udf <= 1'b1;
               else             r_cnt <= r_cnt - CW'(1);
            end
         end
      end
   end

   assign ras_overflow  = r_ovf;
   assign ras_underflow = r_udf;

endmodule
